// File: rtl/vertex_fetch.sv
// Vertex fetch: reads x/y/z words per vertex and presents {x,y,z,1.0}.
// Define VFETCH_NANCHK_EN to flag vertices with non-finite components.
module vertex_fetch #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_verts,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_data,
  output logic [3:0][31:0]    pos,
  output logic                v_out,
  input  logic                ready,
  output logic                busy,
  output logic                done,
  output logic                bad_vert
);

  localparam logic [31:0] ONE = 32'h3f800000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        sub_q;
  logic [1:0]        rd_p;
  logic [1:0]        idx1, idx2;
  logic [31:0]       x_q, y_q, z_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    v_out   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_d = (num_verts == '0) ? DONE : READ;
      end
      READ: begin
        mem_rd = 1'b1;
        if (sub_q == 2'd2) state_d = WAIT;
      end
      WAIT: begin
        // leave once the z word (third read) has landed
        if (rd_p[1] && idx2 == 2'd2) state_d = PRESENT;
      end
      PRESENT: begin
        v_out = 1'b1;
        if (ready)
          state_d = (cnt_q == CNT_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      sub_q  <= '0;
      rd_p   <= '0;
      idx1   <= '0;
      idx2   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else begin
      rd_p <= {rd_p[0], mem_rd};
      idx1 <= sub_q;
      idx2 <= idx1;
      if (state_q == IDLE && start) begin
        addr_q <= base_addr;
        cnt_q  <= num_verts;
        sub_q  <= '0;
      end
      if (mem_rd) begin
        addr_q <= addr_q + ADDR_W'(1);
        sub_q  <= (sub_q == 2'd2) ? 2'd0 : sub_q + 2'd1;
      end
      if (v_out && ready) cnt_q <= cnt_q - CNT_W'(1);
      if (rd_p[1]) begin
        unique case (idx2)
          2'd0:    x_q <= mem_data;
          2'd1:    y_q <= mem_data;
          default: z_q <= mem_data;
        endcase
      end
    end
  end

  assign mem_addr = addr_q;
  assign pos = {x_q, y_q, z_q, v_out ? ONE : 32'h0};

`ifdef VFETCH_NANCHK_EN
  assign bad_vert = v_out &&
    ((&x_q[30:23]) || (&y_q[30:23]) || (&z_q[30:23]));
`else
  assign bad_vert = 1'b0;
`endif

endmodule

// File: tb/tb_vertex_fetch.sv
// Directed bench for vertex_fetch: timing, addresses, backpressure,
// reset mid-batch and the non-finite flag.
module tb_vertex_fetch;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam logic [31:0] ONE = 32'h3f800000;

  logic clk = 0, rst = 0, start = 0, ready = 1;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_verts = '0;
  logic mem_rd, v_out, busy, done, bad_vert;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0][31:0] pos;

  int pass = 0, total = 0;
  int cyc = 0;

  vertex_fetch #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .num_verts(num_verts),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pos(pos), .v_out(v_out), .ready(ready),
    .busy(busy), .done(done), .bad_vert(bad_vert)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] d1 = 32'hDEADBEEF, d2 = 32'hDEADBEEF;
  assign mem_data = d2;
  always @(posedge clk) begin
    d1 <= mem_rd ? mem[mem_addr] : 32'hDEADBEEF;
    d2 <= d1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  int rd_c[$];
  int rd_a[$];
  int vo_c[$];
  logic [127:0] vo_p[$];
  logic vo_b[$];
  int dn_c[$];

  always @(negedge clk) begin
    if (mem_rd) begin
      rd_c.push_back(cyc);
      rd_a.push_back(int'(mem_addr));
    end
    if (v_out && ready) begin
      vo_c.push_back(cyc);
      vo_p.push_back(pos);
      vo_b.push_back(bad_vert);
    end
    if (done) dn_c.push_back(cyc);
  end

  task automatic clr();
    rd_c.delete(); rd_a.delete(); vo_c.delete();
    vo_p.delete(); vo_b.delete(); dn_c.delete();
  endtask

  task automatic kick(input int b, input int n, output int s0);
    @(posedge clk); #1;
    base_addr = AW'(b); num_verts = CW'(n); start = 1; s0 = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (dn_c.size() == 0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({v_out, mem_rd, busy, done, bad_vert} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000",
               {v_out, mem_rd, busy, done, bad_vert});
    else pass++;
    total++;
    if (pos !== '0) $display("FAIL reset_pos got %h want 0", pos);
    else pass++;
    rst = 1;
  endtask

  task automatic test_single();
    int s0;
    logic [127:0] ep;
    mem[0] = 32'h3f800000; mem[1] = 32'h40000000; mem[2] = 32'h40400000;
    ep = {32'h3f800000, 32'h40000000, 32'h40400000, ONE};
    ready = 1; clr();
    kick(0, 1, s0);
    total++;
    if (busy !== 1) $display("FAIL single_busy got %b want 1", busy);
    else pass++;
    wait_done(30);
    total++;
    if (rd_c.size() !== 3) $display("FAIL single_nrd got %0d want 3", rd_c.size());
    else pass++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_c[i] !== s0 + 1 + i || rd_a[i] !== i)
        $display("FAIL single_rd%0d got c%0d a%0d want c%0d a%0d",
                 i, rd_c[i] - s0, rd_a[i], 1 + i, i);
      else pass++;
    end
    total++;
    if (vo_c.size() !== 1 || vo_c[0] !== s0 + 6)
      $display("FAIL single_vout got n%0d c%0d want n1 c6", vo_c.size(), vo_c[0] - s0);
    else pass++;
    total++;
    if (vo_p[0] !== ep) $display("FAIL single_pos got %h want %h", vo_p[0], ep);
    else pass++;
    total++;
    if (vo_b[0] !== 1'b0) $display("FAIL single_bad got %b want 0", vo_b[0]);
    else pass++;
    total++;
    if (dn_c.size() !== 1 || dn_c[0] !== s0 + 7)
      $display("FAIL single_done got n%0d c%0d want n1 c7", dn_c.size(), dn_c[0] - s0);
    else pass++;
    total++;
    if (busy !== 0) $display("FAIL single_idle_busy got %b want 0", busy);
    else pass++;
  endtask

  task automatic test_multi();
    int s0;
    logic [127:0] ep;
    for (int i = 0; i < 9; i++) mem[100 + i] = 32'h41000000 + 32'(i * 16);
    ready = 1; clr();
    kick(100, 3, s0);
    wait_done(60);
    total++;
    if (rd_a.size() !== 9) $display("FAIL multi_nrd got %0d want 9", rd_a.size());
    else pass++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (rd_a[i] !== 100 + i)
        $display("FAIL multi_addr%0d got %0d want %0d", i, rd_a[i], 100 + i);
      else pass++;
    end
    total++;
    if (vo_c.size() !== 3) $display("FAIL multi_nvo got %0d want 3", vo_c.size());
    else pass++;
    for (int j = 0; j < 3; j++) begin
      ep = {mem[100 + 3 * j], mem[101 + 3 * j], mem[102 + 3 * j], ONE};
      total++;
      if (vo_c[j] !== s0 + 6 + 6 * j || vo_p[j] !== ep)
        $display("FAIL multi_vo%0d got c%0d %h want c%0d %h",
                 j, vo_c[j] - s0, vo_p[j], 6 + 6 * j, ep);
      else pass++;
    end
    total++;
    if (dn_c.size() !== 1 || dn_c[0] !== s0 + 19)
      $display("FAIL multi_done got n%0d c%0d want n1 c19", dn_c.size(), dn_c[0] - s0);
    else pass++;
  endtask

  task automatic test_backpressure();
    int s0, k;
    logic [127:0] p0;
    ready = 0; clr();
    kick(200, 2, s0);
    k = 0;
    while (!v_out && k < 20) begin @(posedge clk); #1; k++; end
    total++;
    if (v_out !== 1) $display("FAIL bp_vout_timeout got %b want 1", v_out);
    else pass++;
    p0 = pos;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (v_out !== 1 || pos !== p0 || mem_rd !== 0)
        $display("FAIL bp_hold%0d got v%b rd%b pos %h want v1 rd0 pos %h",
                 i, v_out, mem_rd, pos, p0);
      else pass++;
      @(posedge clk); #1;
    end
    ready = 1;
    wait_done(40);
    total++;
    if (rd_c.size() !== 6 || vo_c.size() !== 2 || rd_c[3] !== vo_c[0] + 1)
      $display("FAIL bp_resume got nrd%0d nvo%0d rd3-hs%0d want 6 2 1",
               rd_c.size(), vo_c.size(), rd_c[3] - vo_c[0]);
    else pass++;
  endtask

  task automatic test_zero();
    int s0;
    ready = 1; clr();
    @(posedge clk); #1;
    base_addr = 5; num_verts = 0; start = 1; s0 = cyc;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (dn_c.size() !== 1 || dn_c[0] !== s0 + 1)
      $display("FAIL zero_done got n%0d c%0d want n1 c1", dn_c.size(), dn_c[0] - s0);
    else pass++;
    total++;
    if (rd_c.size() !== 0 || vo_c.size() !== 0)
      $display("FAIL zero_quiet got nrd%0d nvo%0d want 0 0", rd_c.size(), vo_c.size());
    else pass++;
  endtask

  task automatic test_wrap();
    int s0;
    logic [127:0] ep;
    mem[4094] = 32'h40a00000; mem[4095] = 32'h40c00000; mem[0] = 32'h40e00000;
    ep = {32'h40a00000, 32'h40c00000, 32'h40e00000, ONE};
    ready = 1; clr();
    kick(4094, 1, s0);
    wait_done(30);
    total++;
    if (rd_a.size() !== 3 || rd_a[0] !== 4094 || rd_a[1] !== 4095 || rd_a[2] !== 0)
      $display("FAIL wrap_addr got %0d %0d %0d want 4094 4095 0",
               rd_a[0], rd_a[1], rd_a[2]);
    else pass++;
    total++;
    if (vo_p[0] !== ep) $display("FAIL wrap_pos got %h want %h", vo_p[0], ep);
    else pass++;
  endtask

  task automatic test_reset_mid();
    int s0, k;
    logic [127:0] ep;
    for (int i = 0; i < 6; i++) mem[300 + i] = 32'h42000000 + 32'(i);
    mem[10] = 32'h3f800000; mem[11] = 32'h40000000; mem[12] = 32'h40400000;
    ep = {32'h3f800000, 32'h40000000, 32'h40400000, ONE};
    ready = 1; clr();
    kick(300, 2, s0);
    k = 0;
    while (cyc < s0 + 10 && k < 30) begin @(posedge clk); #1; k++; end
    rst = 0;
    @(posedge clk); #1;
    total++;
    if ({v_out, mem_rd, busy, done, bad_vert} !== 5'b0 || pos !== '0)
      $display("FAIL rstmid_out got %b pos %h want 00000 pos 0",
               {v_out, mem_rd, busy, done, bad_vert}, pos);
    else pass++;
    rst = 1; clr();
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (rd_c.size() !== 0 || vo_c.size() !== 0 || dn_c.size() !== 0)
      $display("FAIL rstmid_quiet got nrd%0d nvo%0d ndn%0d want 0 0 0",
               rd_c.size(), vo_c.size(), dn_c.size());
    else pass++;
    kick(10, 1, s0);
    wait_done(30);
    total++;
    if (vo_c.size() !== 1 || vo_c[0] !== s0 + 6 || vo_p[0] !== ep)
      $display("FAIL rstmid_rerun got n%0d c%0d %h want n1 c6 %h",
               vo_c.size(), vo_c[0] - s0, vo_p[0], ep);
    else pass++;
    total++;
    if (dn_c.size() !== 1 || dn_c[0] !== s0 + 7)
      $display("FAIL rstmid_done got n%0d c%0d want n1 c7", dn_c.size(), dn_c[0] - s0);
    else pass++;
  endtask

  task automatic test_nan();
    int s0;
    logic exp_b;
`ifdef VFETCH_NANCHK_EN
    exp_b = 1'b1;
`else
    exp_b = 1'b0;
`endif
    mem[20] = 32'h3f800000; mem[21] = 32'h7fc00000; mem[22] = 32'h40400000;
    ready = 1; clr();
    kick(20, 1, s0);
    wait_done(30);
    total++;
    if (vo_b.size() !== 1 || vo_b[0] !== exp_b)
      $display("FAIL nan_bad got n%0d b%b want n1 b%b", vo_b.size(), vo_b[0], exp_b);
    else pass++;
    total++;
    if (vo_p[0][95:64] !== 32'h7fc00000)
      $display("FAIL nan_y got %h want 7fc00000", vo_p[0][95:64]);
    else pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_wrap();
    test_nan();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/vertex_fetch.md
VERTEX_FETCH -- requirements
Module: vertex_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, vertex memory word-address width.
REQ-002 SHALL have parameter CNT_W, default 16, vertex-count width.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a vertex batch.
REQ-006 SHALL have port base_addr  input  ADDR_W  word address of first vertex x.
REQ-007 SHALL have port num_verts  input  CNT_W  vertices in batch.
REQ-008 SHALL have port mem_rd  output  1  memory read strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  memory read address.
REQ-010 SHALL have port mem_data  input  32  read data, valid exactly 2 cycles after the mem_rd cycle.
REQ-011 SHALL have port pos  output  32 x [3:0]  IEEE-754 single vertex: [3]=x, [2]=y, [1]=z, [0]=w.
REQ-012 SHALL have port v_out  output  1  pos valid, feeds transformation stage v_in.
REQ-013 SHALL have port ready  input  1  downstream accepts pos when high with v_out.
REQ-014 SHALL have port busy  output  1  high from start accept until done.
REQ-015 SHALL have port done  output  1  one-cycle batch-complete pulse.
REQ-016 SHALL have port bad_vert  output  1  qualifies v_out: vertex has non-finite component.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> WAIT -> PRESENT -> (READ | DONE) -> IDLE.
REQ-018 SHALL in IDLE accept start only; latch base_addr and num_verts; start while busy ignored.
REQ-019 SHALL, if latched num_verts==0, go IDLE -> DONE, pulse done next cycle, issue no reads.
REQ-020 SHALL per vertex i assert mem_rd for 3 consecutive cycles at addresses A, A+1, A+2, A = base_addr + 3*i.
REQ-021 SHALL compute addresses modulo 2^ADDR_W (wrap, no error).
REQ-022 SHALL capture mem_data 2 cycles after each read into x, y, z respectively.
REQ-023 SHALL drive pos[0] = 32'h3f800000 (1.0) whenever v_out is high.
REQ-024 SHALL, for the first vertex, issue reads in cycles 1-3 after the start cycle (cycle 0) and raise v_out in cycle 6.
REQ-025 SHALL hold v_out and pos stable while v_out && !ready.
REQ-026 SHALL treat v_out && ready as handshake; next vertex's first read in the following cycle; no prefetch.
REQ-027 SHALL assert done for one cycle the cycle after the last handshake, then return to IDLE with busy low.
REQ-028 SHALL keep mem_rd low outside READ; mem_addr don't-care when mem_rd low.
REQ-029 SHALL accept a start asserted in the same cycle done is high only from the next cycle (IDLE).

Reset
REQ-030 SHALL on rst low at a rising edge enter IDLE: v_out=0, mem_rd=0, busy=0, done=0, bad_vert=0, pos=0.
REQ-031 SHALL on reset mid-batch discard in-flight read data; no v_out or done until a new start.

Configuration
REQ-032 SHALL use macro VFETCH_NANCHK_EN to compile in the non-finite check.
REQ-033 SHALL with VFETCH_NANCHK_EN defined drive bad_vert=1 with v_out when any of x,y,z has exponent 8'hFF; vertex still presented.
REQ-034 SHALL without VFETCH_NANCHK_EN tie bad_vert to 0; all other behaviour identical.

Verification
REQ-035 SHALL cover: base_addr=0, num_verts=1, mem holds 1.0,2.0,3.0, ready=1 -> reads at 0,1,2 in cycles 1-3, v_out in cycle 6 with pos={3f800000,40000000,40400000,3f800000}, done in cycle 7.
REQ-036 SHALL cover: num_verts=3, ready=1 -> 9 reads at base..base+8, 3 v_out pulses 6 cycles apart, one done.
REQ-037 SHALL cover: ready low 10 cycles on first vertex -> v_out and pos constant for 10 cycles, no mem_rd until handshake.
REQ-038 SHALL cover: num_verts=0 -> done one cycle after start, no mem_rd, no v_out; base_addr=4094, ADDR_W=12 -> addresses 4094,4095,0.
REQ-039 SHALL cover: rst low during second vertex WAIT -> all outputs 0 next cycle; new start then runs normally.
REQ-040 SHALL cover: y word 7fc00000 with VFETCH_NANCHK_EN -> bad_vert=1 with v_out; without macro -> bad_vert=0.
